// File: rtl/array_mem_pkg.sv
// array_mem_pkg -- shared definitions for the array_mem RAM block.
//
// Width macros (`intN, `addrN, `intT, `addrT) and `TRUE/`FALSE are global
// text macros so client code declaring array-typed interfaces can use
// them without importing the package. The package carries the state
// encoding used when the ARRAY_CLEAR_EN build option is defined.

`ifndef ARRAY_MEM_DEFS_SVH
`define ARRAY_MEM_DEFS_SVH
`define intN  8
`define addrN 8
`define intT  logic [`intN-1:0]
`define addrT logic [`addrN-1:0]
`define TRUE  1'b1
`define FALSE 1'b0
`endif

package array_mem_pkg;

    // ST_RUN serves requests; ST_CLEAR exists only with ARRAY_CLEAR_EN.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } array_state_e;

    localparam int DATA_W_DEF = `intN;
    localparam int ADDR_W_DEF = `addrN;

endpackage

// File: rtl/array_mem_clear_ctr.sv
// array_mem_clear_ctr -- address sweep counter for the post-reset clear.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset; restarts the sweep at word 0
//   en    advance enable (high while the parent is in its clear state)
//   addr  word currently being cleared
//   done  high while addr is the last word (DEPTH-1)
//
// Instantiated by array_mem only when ARRAY_CLEAR_EN is defined. The
// counter parks on the last word once done, until the next reset.

module array_mem_clear_ctr
    import array_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] addr,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
        end else if (en && !done) begin
            addr <= addr + 1'b1;
        end
    end

    assign done = (addr == LAST);

endmodule

// File: rtl/array_mem.sv
// array_mem -- single-port synchronous RAM with valid/ready handshake.
//
// One request per cycle, one-cycle latency, no backpressure:
// ready(t+1) = valid(t). Writes are write-through (dout shows the written
// data); reads return the word as it was before any same-cycle write.
// Addresses at or above DEPTH are ignored on write and read back as 0.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset (clears ready/dout, drops the
//          in-flight response, suppresses a write sampled with it)
//   addr   word address of request
//   we     1 = write, 0 = read
//   di     write data
//   valid  request strobe
//   dout   read data / write-through data ("do" is a reserved keyword)
//   ready  response strobe
//
// Build option ARRAY_CLEAR_EN: after reset the array is swept to zero, one
// word per cycle, before requests are accepted. Without it there is no
// clear state and memory contents survive reset.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | sweeping zeros into the array; valid ignored, ready held 0
// ST_RUN   | serving requests

module array_mem
    import array_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] di,
    input  logic              valid,
    output logic [DATA_W-1:0] dout,
    output logic              ready
);

    // Array index width; narrower than ADDR_W when DEPTH < 2**ADDR_W.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              run;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wd;

    assign in_range = (32'(addr) < DEPTH);
    assign idx      = addr[IDX_W-1:0];

`ifdef ARRAY_CLEAR_EN
    array_state_e     state;
    logic             sweeping;
    logic [IDX_W-1:0] clr_addr;
    logic             clr_done;

    assign sweeping = (state == ST_CLEAR);
    assign run      = (state == ST_RUN);

    array_mem_clear_ctr #(
        .DEPTH (DEPTH),
        .CNT_W (IDX_W)
    ) u_clear_ctr (
        .clk  (clk),
        .rst  (rst),
        .en   (sweeping),
        .addr (clr_addr),
        .done (clr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
        end else if (sweeping && clr_done) begin
            state <= ST_RUN;
        end
    end

    // The sweep owns the write port while it runs.
    always_comb begin
        mem_we  = `FALSE;
        mem_idx = idx;
        mem_wd  = di;
        if (!rst) begin
            if (sweeping) begin
                mem_we  = `TRUE;
                mem_idx = clr_addr;
                mem_wd  = '0;
            end else if (valid && we && in_range) begin
                mem_we  = `TRUE;
            end
        end
    end
`else
    assign run = `TRUE;

    always_comb begin
        mem_we  = !rst && valid && we && in_range;
        mem_idx = idx;
        mem_wd  = di;
    end
`endif

    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wd;
        end
    end

    // Registered read port plus handshake. addr/we are only looked at
    // when valid is high, so unknowns on them during idle cycles are inert.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready <= `FALSE;
            dout  <= '0;
        end else if (run && valid) begin
            ready <= `TRUE;
            if (we) begin
                dout <= di;
            end else if (in_range) begin
                dout <= mem[idx];
            end else begin
                dout <= '0;
            end
        end else begin
            ready <= `FALSE;
        end
    end

endmodule

// File: tb/tb_array_mem.sv
`timescale 1ns/1ps
module tb_array_mem;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
`ifdef ARRAY_CLEAR_EN
    localparam int DEPTH = 256;
`else
    localparam int DEPTH = 200;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] di;
    logic              valid;
    logic [DATA_W-1:0] dout;
    logic              ready;

    array_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .we    (we),
        .di    (di),
        .valid (valid),
        .dout  (dout),
        .ready (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        bit         chk;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_mem [256];
    bit         known   [256];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    bit         rst_q  = 1'b1;
    logic [7:0] last_do = 8'h00;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every response, checks reset outputs
    // and that dout holds during idle cycles.
    always @(negedge clk) begin
        exp_t e;
        if (rst_q) begin
            check("reset_ready", {31'd0, ready}, 32'd0);
            check("reset_do", {24'd0, dout}, 32'd0);
            last_do = 8'h00;
        end else if (ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready actual=1 required=0 at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                check("latency", cyc, e.cyc + 1);
                if (e.chk) check("data", {24'd0, dout}, {24'd0, e.data});
            end
            last_do = dout;
        end else begin
            check("hold", {24'd0, dout}, {24'd0, last_do});
        end
    end

    // Drive one cycle of stimulus; a valid request also updates the model
    // and queues its expected response.
    task automatic issue(input bit v, input bit w, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        rst   = 1'b0;
        valid = v;
        we    = v ? w : 1'bx;
        addr  = v ? a : 'x;
        di    = d;
        if (v) begin
            e.cyc = cyc;
            if (w) begin
                if (int'(a) < DEPTH) begin
                    ref_mem[a] = d;
                    known[a]   = 1'b1;
                end
                e.data = d;
                e.chk  = (int'(a) < DEPTH);
            end else begin
                e.data = (int'(a) < DEPTH) ? ref_mem[a] : 8'h00;
                e.chk  = 1'b1;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            valid = 1'b0;
            n++;
        end
        @(negedge clk);
        valid = 1'b0;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Reset for n cycles while presenting a request that must be dropped.
    task automatic do_reset(input int n, input bit w, input logic [7:0] a, input logic [7:0] d);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst   = 1'b1;
            valid = 1'b1;
            we    = w;
            addr  = a;
            di    = d;
        end
    endtask

`ifdef ARRAY_CLEAR_EN
    // Release reset with a write to addr 3 held on the bus; it must be
    // ignored, and no response may appear for DEPTH cycles.
    task automatic release_into_sweep(input int cycles);
        @(negedge clk);
        rst   = 1'b0;
        valid = 1'b1;
        we    = 1'b1;
        addr  = 8'd3;
        di    = 8'hEE;
        repeat (cycles - 1) @(negedge clk);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'h00;
            known[i]   = 1'b1;
        end
    endtask
`endif

    initial begin
        rst   = 1'b1;
        valid = 1'b1;
        we    = 1'b0;
        addr  = '0;
        di    = '0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'h00;
            known[i]   = 1'b0;
        end

        do_reset(2, 1'b1, 8'd7, 8'h33);
`ifdef ARRAY_CLEAR_EN
        release_into_sweep(DEPTH);
        model_clear();
`endif

        // Write burst then read back.
        for (int a = 0; a < 16; a++) issue(1'b1, 1'b1, 8'(a), 8'(a));
        for (int a = 0; a < 16; a++) issue(1'b1, 1'b0, 8'(a), 8'h00);

        // Read-after-write on consecutive cycles.
        issue(1'b1, 1'b1, 8'd5, 8'hAA);
        issue(1'b1, 1'b0, 8'd5, 8'h00);

        // Alternating valid with unknown addr/we in the gaps.
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 1'(i % 2), 8'(i + 1), 8'(8'h40 + i));
            issue(1'b0, 1'b0, 8'h00, 8'hxx);
        end

`ifndef ARRAY_CLEAR_EN
        // Last valid word and out-of-range accesses.
        issue(1'b1, 1'b1, 8'd199, 8'h99);
        issue(1'b1, 1'b1, 8'd250, 8'h55);
        issue(1'b1, 1'b0, 8'd250, 8'h00);
        issue(1'b1, 1'b0, 8'd199, 8'h00);
        issue(1'b1, 1'b0, 8'd200, 8'h00);
`endif
        drain();

        // A write sampled together with reset must not land.
        do_reset(1, 1'b1, 8'd7, 8'h33);
`ifdef ARRAY_CLEAR_EN
        release_into_sweep(DEPTH);
        model_clear();
`endif
        issue(1'b1, 1'b0, 8'd7, 8'h00);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit         v;
            bit         w;
            logic [7:0] a;
            v = ($urandom_range(0, 9) < 7);
            w = 1'($urandom);
            a = 8'($urandom_range(0, 255));
            if (!w && int'(a) < DEPTH && !known[a]) w = 1'b1;
            issue(v, w, a, 8'($urandom));
        end
        drain();

`ifdef ARRAY_CLEAR_EN
        // Clear sweep wipes a prefilled word; reset mid-sweep restarts it.
        issue(1'b1, 1'b1, 8'd3, 8'h77);
        issue(1'b1, 1'b0, 8'd3, 8'h00);
        drain();
        do_reset(1, 1'b0, 8'd0, 8'h00);
        release_into_sweep(100);
        do_reset(1, 1'b0, 8'd0, 8'h00);
        release_into_sweep(DEPTH);
        model_clear();
        issue(1'b1, 1'b0, 8'd3, 8'h00);
        issue(1'b1, 1'b0, 8'd255, 8'h00);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/array_mem.md
Name: array_mem

Overview:
- Single-port synchronous RAM with a valid/ready request handshake.
- Serves as the backing store for array-typed interfaces: a stream-to-array reader or similar client drives addr/we/di/valid and consumes do/ready.
- One request per cycle, one-cycle latency, fully pipelined.

Parameters:
- DATA_W, 8, word width in bits (matches `intN).
- ADDR_W, 8, address width in bits (matches `addrN).
- DEPTH, 2**ADDR_W, number of words. Must be no greater than 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- addr  input  ADDR_W  word address of request
- we  input  1  1 = write, 0 = read
- di  input  DATA_W  write data
- valid  input  1  request strobe; addr/we/di are sampled when valid=1 on a rising edge
- do  output  DATA_W  read data, or write-through data
- ready  output  1  response strobe; do is valid and any write is committed

Behaviour:
- Reset (rst=1 at posedge):
  - ready <= 0, do <= 0.
  - Any in-flight response is dropped.
  - Memory contents are unaffected unless ARRAY_CLEAR_EN is defined.
  - Reset mid-operation aborts the pending response; a write sampled in the same cycle as rst is not performed.
- States:
  - RUN.
  - CLEAR, which exists only with ARRAY_CLEAR_EN.
  - After reset: RUN if ARRAY_CLEAR_EN is not defined, otherwise CLEAR.
- RUN, each posedge with valid=1:
  - we=1: mem[addr] <= di; do <= di (write-through); ready <= 1.
  - we=0: do <= mem[addr] (value before any same-cycle write); ready <= 1.
- RUN, valid=0: ready <= 0; do holds its last value.
- Latency and throughput:
  - Latency is exactly 1 cycle: ready(t+1) = valid(t).
  - Back-to-back requests are accepted every cycle; there is no backpressure.
  - Clients must treat each cycle valid=1 as a distinct request.
- Address range:
  - addr >= DEPTH: a write is ignored, a read returns 0, and ready still pulses.
  - No wrap-around.
- Read-after-write to the same address on consecutive cycles returns the new data; the write commits in the cycle it is sampled.
- Memory is inferable as block RAM: a single registered read port, with no reset on the memory array itself.
- X on addr/we while valid=0 must not affect state.

Optional Feature:
- Macro: ARRAY_CLEAR_EN.
- Defined:
  - Reset enters CLEAR.
  - An internal counter sweeps 0..DEPTH-1, writing 0 to one word per cycle.
  - valid is ignored and ready stays 0 during the sweep.
  - Enters RUN on the cycle after word DEPTH-1 is written.
  - Total: DEPTH cycles from rst deasserting to the first accepted request.
  - Reasserting rst during CLEAR restarts the sweep at 0.
- Not defined:
  - No clear counter or CLEAR state.
  - Memory powers up undefined (X in simulation).
  - The first request is accepted on the first cycle after rst deasserts.

Decomposition:
- Shared package/header holds:
  - Width macros: `intN, `addrN, `intT, `addrT.
  - `true/`false.
  - State encoding constants ST_RUN and ST_CLEAR.
- One natural sub-module: array_mem_clear_ctr, the sweep counter and done flag, instantiated only under ARRAY_CLEAR_EN.
- The RAM core stays in array_mem.

Test Plan:
- Reset: hold rst=1 for 2 cycles with valid=1 -> ready=0 and do=0 throughout; the first ready appears 1 cycle after rst falls (without ARRAY_CLEAR_EN).
- Write burst: valid=1, we=1, addr=0..15, di=addr on consecutive cycles -> ready=1 on each following cycle with do=di; then reads of addr 0..15 return 0..15 with ready one cycle after each.
- Read-after-write: write addr=5 di=0xAA, then next cycle read addr=5 -> do=0xAA, ready=1.
- Idle gaps: alternate valid 1/0 -> ready pulses alternate and do holds during gaps.
- Out of range: with DEPTH=200, write addr=250 di=0x55 then read addr=250 -> do=0 and ready pulses for both.
- ARRAY_CLEAR_EN: prefill addr 3 with 0x77, then rst -> ready=0 for DEPTH=256 cycles with valid held high; a read of addr 3 then returns 0; rst at sweep cycle 100 restarts the full 256-cycle sweep.
